fetch_stage: RTL and testbench

//   Instruction fetch front end. Owns the PC, drives the byte address into the

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_skid.sv | 49 ++++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Word width, the reset PC default and the PC increment live here.
package fetch_stage_pkg;

  localparam int WORD_LEN = 32;

  typedef logic [WORD_LEN-1:0] word_t;

  localparam word_t START_ADDR_DEFAULT = 32'h0000_0000;
  localparam word_t INST_LEN_BYTES     = 32'd4;

  // A fetched instruction paired with the address it was read from.
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_pkt_t;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic word_t align_pc(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry hold buffer for a fetched instruction that decode could not take,
// plus the mux that presents either the held entry or the live imem response.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture_i,
  input  logic       drain_i,
  input  logic       flush_i,
  input  fetch_pkt_t rsp_i,
  output logic       skid_v_o,
  output fetch_pkt_t out_o
);

  logic       skid_v_q, skid_v_d;
  fetch_pkt_t skid_q,   skid_d;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush_i) begin
      skid_v_d = 1'b0;
    end else if (capture_i) begin
      skid_v_d = 1'b1;
      skid_d   = rsp_i;
    end else if (drain_i) begin
      skid_v_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments; the data fields are
  // reset too, so a discarded entry never leaks X or stale values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end

  assign skid_v_o = skid_v_q;
  assign out_o    = skid_v_q ? skid_q : rsp_i;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle synchronous imem,
// and hands (pc, inst) to decode with stall absorption and redirect support.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t START_ADDR = START_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic [WORD_LEN-1:0] imem_inst,
  input  logic                redirect_valid,
  input  logic [WORD_LEN-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_pc,
  output logic [WORD_LEN-1:0] out_inst
);

  word_t      pc_q, pc_d;
  logic       rsp_v_q, rsp_v_d;
  word_t      rsp_pc_q, rsp_pc_d;

  logic       skid_v;
  logic       any_v;
  logic       issue;
  logic       capture;
  logic       drain;
  fetch_pkt_t rsp_pkt;
  fetch_pkt_t out_pkt;

  // Redirect outranks everything: it blocks issue, capture and the handoff.
  assign any_v     = skid_v | rsp_v_q;
  assign out_valid = any_v & ~redirect_valid;
  assign issue     = ~redirect_valid & (~any_v | out_ready);
  assign capture   = rsp_v_q & ~skid_v & ~out_ready & ~redirect_valid;
  assign drain     = skid_v & out_ready;

  always_comb begin
    pc_d     = pc_q;
    rsp_v_d  = 1'b0;
    rsp_pc_d = rsp_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      rsp_v_d  = 1'b1;
      rsp_pc_d = pc_q;
      pc_d     = pc_q + INST_LEN_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= START_ADDR;
      rsp_v_q  <= 1'b0;
      rsp_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_v_q  <= rsp_v_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

  assign rsp_pkt = '{pc: rsp_pc_q, inst: imem_inst};

  fetch_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture),
    .drain_i   (drain),
    .flush_i   (redirect_valid),
    .rsp_i     (rsp_pkt),
    .skid_v_o  (skid_v),
    .out_o     (out_pkt)
  );

  assign imem_addr = pc_q;
  assign out_pc    = out_pkt.pc;
  assign out_inst  = out_pkt.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random run,
// all compared against a one-slot "presented instruction" reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t START = 32'h0000_0000;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t imem_addr;
  word_t imem_inst;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  out_valid;
  logic  out_ready;
  word_t out_pc;
  word_t out_inst;

  fetch_stage #(.START_ADDR(START)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  // Instruction memory: preloaded array, registered read one cycle after addr.
  word_t mem [256];
  always @(posedge clk) imem_inst <= mem[imem_addr[9:2]];

  // Reference model: whether decode is being shown an instruction, its PC,
  // and the next address fetch will read.
  bit    m_have;
  word_t m_shown_pc;
  word_t m_next;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t acc [$];

  // One clock cycle: drive inputs at negedge, compare against the model,
  // then advance the model with the rules applied at the posedge.
  task automatic cycle(input bit rdy, input bit rv, input word_t rpc, input bit rst);
    bit exp_v;
    rst_n          = ~rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_v = m_have & ~rv;
    n_tests++;
    if (out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL out_valid t=%0t: got %b want %b", $time, out_valid, exp_v);
    end
    n_tests++;
    if (imem_addr !== m_next) begin
      n_fail++;
      $display("FAIL imem_addr t=%0t: got %h want %h", $time, imem_addr, m_next);
    end
    if (exp_v) begin
      n_tests++;
      if (out_pc !== m_shown_pc) begin
        n_fail++;
        $display("FAIL out_pc t=%0t: got %h want %h", $time, out_pc, m_shown_pc);
      end
      n_tests++;
      if (out_inst !== mem[m_shown_pc[9:2]]) begin
        n_fail++;
        $display("FAIL out_inst t=%0t: got %h want %h", $time, out_inst,
                 mem[m_shown_pc[9:2]]);
      end
    end
    if (out_valid === 1'b1 && rdy) acc.push_back(out_pc);
    @(posedge clk);
    if (rst) begin
      m_have = 1'b0;
      m_next = START;
    end else if (rv) begin
      m_have = 1'b0;
      m_next = rpc & ~32'h3;
    end else if (!m_have || rdy) begin
      m_have     = 1'b1;
      m_shown_pc = m_next;
      m_next     = m_next + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    acc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    @(negedge clk);
    m_have = 1'b0; m_next = START; m_shown_pc = '0;
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== START) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b addr=%h want 0/%h", out_valid, imem_addr, START);
    end
    reset_dut();
  endtask

  task automatic test_stream();
    reset_dut();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (acc.size() != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want 4", acc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (acc[i] !== word_t'(4 * i)) begin
          n_fail++;
          $display("FAIL stream_pc[%0d]: got %h want %h", i, acc[i], 4 * i);
        end
      end
    end
  endtask

  task automatic test_stall();
    word_t want [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_inst !== mem[2]) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h inst=%h want 1/8/%h",
                 i, out_valid, out_pc, out_inst, mem[2]);
      end
      cycle(1'b0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (acc.size() != 6) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want 6", acc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (acc[i] !== want[i]) begin
          n_fail++;
          $display("FAIL stall_seq[%0d]: got %h want %h", i, acc[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (out_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL redir_pre: got %h want 10", out_pc);
    end
    cycle(1'b1, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (acc.size() != 6 || acc[4] !== 32'h40 || acc[5] !== 32'h44) begin
      n_fail++;
      $display("FAIL redir_seq: size=%0d last=%h want 6 ending 40,44",
               acc.size(), acc[acc.size()-1]);
    end
  endtask

  task automatic test_redirect_in_stall();
    reset_dut();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 32'h23, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (acc.size() != 7 || acc[5] !== 32'h20 || acc[6] !== 32'h24) begin
      n_fail++;
      $display("FAIL skid_flush: size=%0d got %h,%h want 7 with 20,24",
               acc.size(), acc[acc.size()-2], acc[acc.size()-1]);
    end
    foreach (acc[i]) begin
      if (acc[i] === 32'h14) begin
        n_fail++;
        $display("FAIL skid_flush_leak: got 14 accepted want none");
      end
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (acc.size() != 3 || acc[0] !== 32'hFFFF_FFFC || acc[1] !== 32'h0 || acc[2] !== 32'h4) begin
      n_fail++;
      $display("FAIL wrap_seq: size=%0d first=%h want 3 of FFFFFFFC,0,4", acc.size(), acc[0]);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== START) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b addr=%h want 0/%h", out_valid, imem_addr, START);
    end
    acc.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (acc.size() != 2 || acc[0] !== START || acc[1] !== START + 32'd4) begin
      n_fail++;
      $display("FAIL reset_restart: size=%0d first=%h want 2 from %h", acc.size(), acc[0], START);
    end
  endtask

  task automatic test_random();
    bit    rdy, rv, rst;
    word_t rpc;
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      rpc = ($urandom_range(0, 1) == 1) ? word_t'($urandom_range(0, 1023))
                                        : ($urandom | 32'hFFFF_FF00);
      cycle(rdy, rv, rpc, rst);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_in_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
